// File: rtl/bcd2hex.sv
// Converts two 2-digit BCD pairs into binary h_val/l_val using a sequential reverse double-dabble.
// Start/done handshake; a conversion with a non-decimal digit or an out-of-range pair reports err and holds the outputs.
module bcd2hex_top #(
    parameter int H_W   = 6,
    parameter int L_W   = 7,
    parameter int H_MAX = 59,
    parameter int L_MAX = 99
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [3:0]     bcd_a,
    input  logic [3:0]     bcd_b,
    input  logic [3:0]     bcd_c,
    input  logic [3:0]     bcd_d,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [H_W-1:0] h_val,
    output logic [L_W-1:0] l_val
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    localparam logic [6:0] H_LIM = 7'(H_MAX);
    localparam logic [6:0] L_LIM = 7'(L_MAX);

    logic [1:0] state;
    logic [7:0] hbcd, lbcd;
    logic [6:0] hbin, lbin;
    logic [2:0] cnt;
    logic       bad_dig;

    logic [7:0] hbcd_sh, lbcd_sh;
    logic [6:0] hbin_sh, lbin_sh;
    logic       err_n;

    // After each right shift, a nibble that received a carried-in 8 is corrected back to decimal by subtracting 3.
    function automatic logic [7:0] fix_nibbles(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (r[7:4] >= 4'd8) r[7:4] = r[7:4] - 4'd3;
        if (r[3:0] >= 4'd8) r[3:0] = r[3:0] - 4'd3;
        return r;
    endfunction

    always_comb begin
        hbcd_sh = fix_nibbles({1'b0, hbcd[7:1]});
        lbcd_sh = fix_nibbles({1'b0, lbcd[7:1]});
        hbin_sh = {hbcd[0], hbin[6:1]};
        lbin_sh = {lbcd[0], lbin[6:1]};
        err_n   = bad_dig | (hbin > H_LIM) | (lbin > L_LIM);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            hbcd    <= '0;
            lbcd    <= '0;
            hbin    <= '0;
            lbin    <= '0;
            cnt     <= '0;
            bad_dig <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            h_val   <= '0;
            l_val   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        hbcd    <= {bcd_a, bcd_b};
                        lbcd    <= {bcd_c, bcd_d};
                        hbin    <= '0;
                        lbin    <= '0;
                        bad_dig <= (bcd_a > 4'd9) | (bcd_b > 4'd9) |
                                   (bcd_c > 4'd9) | (bcd_d > 4'd9);
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    hbcd <= hbcd_sh;
                    lbcd <= lbcd_sh;
                    hbin <= hbin_sh;
                    lbin <= lbin_sh;
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd6) state <= S_CHECK;
                end
                S_CHECK: begin
                    if (!err_n) begin
                        h_val <= hbin[H_W-1:0];
                        l_val <= lbin[L_W-1:0];
                    end
                    err   <= err_n;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
